// File: rtl/uart_echo_fifo.sv
// UART echo engine: serial RX -> FIFO -> serial TX with false-start rejection,
// framing/parity/overflow pulses and tx_en flow control. Parity via `UART_PARITY_EN.
module uart_echo_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int UART_BPS   = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY_ODD = 0,
  localparam int AW        = $clog2(FIFO_DEPTH)
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          rx,
  input  logic          tx_en,
  output logic          tx,
  output logic [AW:0]   fifo_cnt,
  output logic          frame_err,
  output logic          parity_err,
  output logic          overflow
);

  localparam int BIT_CNT = CLK_FREQ / UART_BPS;
  localparam int CW      = $clog2(BIT_CNT);
  localparam int BW      = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(BIT_CNT / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [AW:0]   DEPTH_V  = (AW+1)'(FIFO_DEPTH);

  if (BIT_CNT < 4 || DATA_BITS < 5 || DATA_BITS > 8 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : gBadConfig
    $error("uart_echo_fifo: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rxState_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } txState_t;

  logic                 r_rxSync1, r_rxSync2, r_rxPrev;
  rxState_t             r_rxState, w_rxNext;
  logic [CW-1:0]        r_rxCnt;
  logic [BW-1:0]        r_rxBitIdx;
  logic [DATA_BITS-1:0] r_rxShift;
  logic                 w_rxFall, w_rxSample, w_rxStopSample;
  logic                 w_rxParBad;
  logic                 w_goodFrame, w_push;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wrPtr, r_rdPtr;
  logic [AW:0]          r_count;
  logic                 w_full, w_pop;
  logic [DATA_BITS-1:0] w_popData;

  txState_t             r_txState, w_txNext;
  logic [CW-1:0]        r_txCnt;
  logic [BW-1:0]        r_txBitIdx;
  logic                 r_txStopIdx;
  logic [DATA_BITS-1:0] r_txShift;
  logic                 w_txBit, w_txBitEnd;
  logic                 r_tx;
  logic                 r_frameErr, r_overflow;

  // Two flops tame metastability; the third gives the previous level for edge detect.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_rxSync1 <= 1'b1;
      r_rxSync2 <= 1'b1;
      r_rxPrev  <= 1'b1;
    end else begin
      r_rxSync1 <= rx;
      r_rxSync2 <= r_rxSync1;
      r_rxPrev  <= r_rxSync2;
    end
  end

  assign w_rxFall = r_rxPrev & ~r_rxSync2;

  always_comb begin
    w_rxNext       = r_rxState;
    w_rxSample     = 1'b0;
    w_rxStopSample = 1'b0;
    unique case (r_rxState)
      RX_IDLE: begin
        if (w_rxFall) w_rxNext = RX_START;
      end
      RX_START: begin
        if (r_rxCnt == CNT_HALF) begin
          w_rxSample = 1'b1;
          w_rxNext   = r_rxSync2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_rxCnt == CNT_LAST) begin
          w_rxSample = 1'b1;
          if (r_rxBitIdx == BIT_LAST) begin
`ifdef UART_PARITY_EN
            w_rxNext = RX_PARITY;
`else
            w_rxNext = RX_STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (r_rxCnt == CNT_LAST) begin
          w_rxSample = 1'b1;
          w_rxNext   = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (r_rxCnt == CNT_LAST) begin
          w_rxSample     = 1'b1;
          w_rxStopSample = 1'b1;
          w_rxNext       = RX_IDLE;
        end
      end
      default: w_rxNext = RX_IDLE;
    endcase
  end

`ifdef UART_PARITY_EN
  logic r_rxParBad;
  assign w_rxParBad = r_rxParBad;
`else
  assign w_rxParBad = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_rxState  <= RX_IDLE;
      r_rxCnt    <= '0;
      r_rxBitIdx <= '0;
      r_rxShift  <= '0;
`ifdef UART_PARITY_EN
      r_rxParBad <= 1'b0;
`endif
    end else begin
      r_rxState <= w_rxNext;
      if (r_rxState == RX_IDLE || w_rxSample) r_rxCnt <= '0;
      else                                    r_rxCnt <= r_rxCnt + 1'b1;
      if (r_rxState == RX_IDLE) begin
        r_rxBitIdx <= '0;
      end else if (r_rxState == RX_DATA && w_rxSample) begin
        r_rxShift  <= {r_rxSync2, r_rxShift[DATA_BITS-1:1]};
        r_rxBitIdx <= (r_rxBitIdx == BIT_LAST) ? '0 : r_rxBitIdx + 1'b1;
      end
`ifdef UART_PARITY_EN
      if (r_rxState == RX_PARITY && w_rxSample)
        r_rxParBad <= r_rxSync2 ^ (^r_rxShift) ^ 1'(PARITY_ODD);
`endif
    end
  end

  // A full FIFO still accepts a frame when TX drains an entry in the same cycle.
  assign w_full      = (r_count == DEPTH_V);
  assign w_goodFrame = w_rxStopSample & r_rxSync2 & ~w_rxParBad;
  assign w_push      = w_goodFrame & (~w_full | w_pop);
  assign w_pop       = (r_txState == TX_IDLE) && (r_count != '0) && tx_en;
  assign w_popData   = r_mem[r_rdPtr];

  always_ff @(posedge sys_clk) begin
    if (w_push) r_mem[r_wrPtr] <= r_rxShift;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_frameErr <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_frameErr <= w_rxStopSample & ~r_rxSync2;
      r_overflow <= w_goodFrame & w_full & ~w_pop;
    end
  end

`ifdef UART_PARITY_EN
  logic r_parityErr;
  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_parityErr <= 1'b0;
    else         r_parityErr <= w_rxStopSample & r_rxSync2 & r_rxParBad;
  end
  assign parity_err = r_parityErr;
`else
  assign parity_err = 1'b0;
`endif

  assign w_txBitEnd = (r_txState != TX_IDLE) && (r_txCnt == CNT_LAST);

`ifdef UART_PARITY_EN
  logic r_txParity;
`endif

  always_comb begin
    w_txNext = r_txState;
    w_txBit  = 1'b1;
    unique case (r_txState)
      TX_IDLE: begin
        if (w_pop) w_txNext = TX_START;
      end
      TX_START: begin
        w_txBit = 1'b0;
        if (w_txBitEnd) w_txNext = TX_DATA;
      end
      TX_DATA: begin
        w_txBit = r_txShift[0];
        if (w_txBitEnd && r_txBitIdx == BIT_LAST) begin
`ifdef UART_PARITY_EN
          w_txNext = TX_PARITY;
`else
          w_txNext = TX_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        w_txBit = r_txParity;
        if (w_txBitEnd) w_txNext = TX_STOP;
      end
`endif
      TX_STOP: begin
        if (w_txBitEnd && r_txStopIdx == STOP_LAST) w_txNext = TX_IDLE;
      end
      default: w_txNext = TX_IDLE;
    endcase
  end

  // tx is registered from the current state's bit, so it trails the state by one clock.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_txState   <= TX_IDLE;
      r_txCnt     <= '0;
      r_txBitIdx  <= '0;
      r_txStopIdx <= 1'b0;
      r_txShift   <= '0;
      r_tx        <= 1'b1;
`ifdef UART_PARITY_EN
      r_txParity  <= 1'b0;
`endif
    end else begin
      r_txState <= w_txNext;
      r_tx      <= w_txBit;
      if (r_txState == TX_IDLE || w_txBitEnd) r_txCnt <= '0;
      else                                    r_txCnt <= r_txCnt + 1'b1;
      if (w_pop) begin
        r_txShift   <= w_popData;
        r_txBitIdx  <= '0;
        r_txStopIdx <= 1'b0;
`ifdef UART_PARITY_EN
        r_txParity  <= (^w_popData) ^ 1'(PARITY_ODD);
`endif
      end else if (w_txBitEnd) begin
        if (r_txState == TX_DATA) begin
          r_txShift  <= {1'b0, r_txShift[DATA_BITS-1:1]};
          r_txBitIdx <= (r_txBitIdx == BIT_LAST) ? '0 : r_txBitIdx + 1'b1;
        end
        if (r_txState == TX_STOP)
          r_txStopIdx <= (r_txStopIdx == STOP_LAST) ? 1'b0 : ~r_txStopIdx;
      end
    end
  end

  assign tx        = r_tx;
  assign fifo_cnt  = r_count;
  assign frame_err = r_frameErr;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Scoreboard bench for uart_echo_fifo: frames driven on rx, echoes decoded from tx.
module tb_uart_echo_fifo;

  localparam int BIT_CNT = 10;
  localparam int HALF    = BIT_CNT / 2;
  localparam int DEPTH   = 4;

  logic       sys_clk, sys_rst, rx, tx_en;
  logic       tx, frame_err, parity_err, overflow;
  logic [2:0] fifo_cnt;

  uart_echo_fifo #(
    .CLK_FREQ(1_000_000), .UART_BPS(100_000), .DATA_BITS(8),
    .STOP_BITS(1), .FIFO_DEPTH(DEPTH), .PARITY_ODD(0)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .rx(rx), .tx_en(tx_en),
    .tx(tx), .fifo_cnt(fifo_cnt), .frame_err(frame_err),
    .parity_err(parity_err), .overflow(overflow)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] expQ[$];

  int monStarts = 0, monFrames = 0, monLastStart = 0;
  int startLog[$];
  int pushCyc = 0, popCyc = 0, pushEvents = 0;
  int frameErrCnt = 0, parErrCnt = 0, ovfCnt = 0;
  logic [2:0] prevCnt = 3'd0;
  logic monSawReset;
  logic [7:0] monData;
  logic monStop;
  int monLow;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (prevCnt === 3'd0 && fifo_cnt === 3'd1) pushCyc = cyc;
    if (prevCnt === 3'd1 && fifo_cnt === 3'd0) popCyc = cyc;
    if (!$isunknown(fifo_cnt) && fifo_cnt > prevCnt) pushEvents++;
    if (!$isunknown(fifo_cnt)) prevCnt = fifo_cnt;
    if (frame_err === 1'b1)  frameErrCnt++;
    if (parity_err === 1'b1) parErrCnt++;
    if (overflow === 1'b1)   ovfCnt++;
  end

  task automatic monStep();
    @(negedge sys_clk);
    if (sys_rst) monSawReset = 1'b1;
  endtask

  // Decodes each tx frame at bit midpoints; frames interrupted by reset are not scored.
  always begin : txMonitor
    @(negedge sys_clk);
    if (tx === 1'b0) begin
      monStarts++;
      monLastStart = cyc;
      startLog.push_back(cyc);
      monSawReset = sys_rst;
      monLow = 0;
      for (int k = 0; k < BIT_CNT; k++) begin
        if (tx === 1'b0) monLow++;
        monStep();
      end
      for (int b = 0; b < 8; b++) begin
        repeat (HALF) monStep();
        monData[b] = tx;
        repeat (BIT_CNT - HALF) monStep();
      end
`ifdef UART_PARITY_EN
      repeat (HALF) monStep();
      if (!monSawReset) checkOutput("txParity", tx, ^monData);
      repeat (BIT_CNT - HALF) monStep();
`endif
      repeat (HALF) monStep();
      monStop = tx;
      repeat (BIT_CNT - HALF - 1) monStep();
      if (!monSawReset) begin
        checkOutput("txStartLen", monLow, BIT_CNT);
        checkOutput("txStop", monStop, 1);
        if (expQ.size() == 0) checkOutput("txUnexpected", expQ.size(), 1);
        else checkOutput("txData", monData, expQ.pop_front());
        monFrames++;
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: time %0t, no completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic sendBit(input logic b);
    rx = b;
    repeat (BIT_CNT) @(posedge sys_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                               input logic badPar);
    @(posedge sys_clk); #1;
    sendBit(1'b0);
    for (int b = 0; b < 8; b++) sendBit(data[b]);
`ifdef UART_PARITY_EN
    sendBit((^data) ^ badPar);
`endif
    sendBit(stopBit);
    rx = 1'b1;
    repeat (2 * BIT_CNT) @(posedge sys_clk);
    #1;
  endtask

  task automatic waitFrames(input int target, input int budget);
    int n = 0;
    while (monFrames < target && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    checkOutput("frameWait", monFrames, target);
  endtask

  int s0, e0, f0, p0, o0, g;

  initial begin
    sys_rst = 1'b1; rx = 1'b1; tx_en = 1'b1;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    checkOutput("rstTx", tx, 1);
    checkOutput("rstCnt", fifo_cnt, 0);
    checkOutput("rstErr", {frame_err, parity_err, overflow}, 0);
    @(posedge sys_clk); #1 sys_rst = 1'b0;

    $display("[TB] echo 0x55");
    expQ.push_back(8'h55);
    applyStimulus(8'h55, 1'b1, 1'b0);
    waitFrames(1, 300);
    checkOutput("cntOneThenZero", popCyc - pushCyc, 1);
    checkOutput("pushToStart", monLastStart - pushCyc, 2);
    checkOutput("cntAfterEcho", fifo_cnt, 0);

    $display("[TB] false start");
    s0 = monStarts; e0 = pushEvents; f0 = frameErrCnt + parErrCnt + ovfCnt;
    @(posedge sys_clk); #1 rx = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1 rx = 1'b1;
    repeat (200) @(posedge sys_clk);
    checkOutput("falsePush", pushEvents - e0, 0);
    checkOutput("falseErr", frameErrCnt + parErrCnt + ovfCnt - f0, 0);
    checkOutput("falseTx", monStarts - s0, 0);

    $display("[TB] framing error");
    s0 = monStarts; e0 = pushEvents; f0 = frameErrCnt;
    applyStimulus(8'hA3, 1'b0, 1'b0);
    repeat (50) @(posedge sys_clk);
    checkOutput("frameErrPulse", frameErrCnt - f0, 1);
    checkOutput("frameErrCnt", fifo_cnt, 0);
    checkOutput("frameErrPush", pushEvents - e0, 0);
    checkOutput("frameErrTx", monStarts - s0, 0);

`ifdef UART_PARITY_EN
    $display("[TB] parity");
    p0 = parErrCnt; e0 = pushEvents; f0 = monFrames;
    applyStimulus(8'hA3, 1'b1, 1'b1);
    repeat (50) @(posedge sys_clk);
    checkOutput("parErrPulse", parErrCnt - p0, 1);
    checkOutput("parErrPush", pushEvents - e0, 0);
    expQ.push_back(8'hA3);
    applyStimulus(8'hA3, 1'b1, 1'b0);
    waitFrames(f0 + 1, 300);
    checkOutput("parGoodNoErr", parErrCnt - p0, 1);
`endif

    $display("[TB] overflow and back-to-back drain");
    tx_en = 1'b0;
    o0 = ovfCnt; f0 = monFrames;
    for (int i = 1; i <= 6; i++) begin
      if (i <= DEPTH) expQ.push_back(8'(i));
      applyStimulus(8'(i), 1'b1, 1'b0);
      checkOutput("ovfFillCnt", fifo_cnt, (i > DEPTH) ? DEPTH : i);
      checkOutput("ovfPulses", ovfCnt - o0, (i > DEPTH) ? i - DEPTH : 0);
    end
    @(posedge sys_clk); #1 tx_en = 1'b1;
    waitFrames(f0 + DEPTH, 700);
    checkOutput("drainCnt", fifo_cnt, 0);
    for (int k = startLog.size() - DEPTH + 1; k < startLog.size(); k++) begin
      g = startLog[k] - startLog[k-1];
`ifdef UART_PARITY_EN
      checkOutput("b2bGap", (g >= 11 * BIT_CNT && g <= 11 * BIT_CNT + 1), 1);
`else
      checkOutput("b2bGap", (g >= 10 * BIT_CNT && g <= 10 * BIT_CNT + 1), 1);
`endif
    end

    $display("[TB] reset during TX data bit 3");
    tx_en = 1'b0;
    expQ.push_back(8'hA3);
    expQ.push_back(8'h5A);
    applyStimulus(8'hA3, 1'b1, 1'b0);
    applyStimulus(8'h5A, 1'b1, 1'b0);
    s0 = monStarts;
    @(posedge sys_clk); #1 tx_en = 1'b1;
    for (int n = 0; n < 50 && monStarts == s0; n++) @(negedge sys_clk);
    checkOutput("rstFrameStart", monStarts - s0, 1);
    while (cyc < monLastStart + 4 * BIT_CNT + 4) @(negedge sys_clk);
    checkOutput("preRstTx", tx, 0);
    checkOutput("preRstCnt", fifo_cnt, 1);
    @(posedge sys_clk); #1 sys_rst = 1'b1;
    @(posedge sys_clk); #1 sys_rst = 1'b0;
    @(negedge sys_clk);
    checkOutput("postRstTx", tx, 1);
    checkOutput("postRstCnt", fifo_cnt, 0);
    expQ.delete();
    repeat (400) @(posedge sys_clk);
    checkOutput("postRstNoTx", monStarts - s0, 1);
    checkOutput("postRstCntLate", fifo_cnt, 0);

    checkOutput("sbDrained", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
